// File: rtl/sm_to_twos_pkg.sv
// sm_to_twos_pkg
// Shared constants and helpers for the bit-serial sign-magnitude to
// two's-complement converter.
//   ST_*        : FSM state encodings (IDLE, CONVERT, DONE)
//   pos_max()   : largest positive value representable in a WIDTH-bit word
//   neg_max()   : magnitude of the most negative WIDTH-bit value
//   cnt_width() : bits needed for a counter that reaches WIDTH
package sm_to_twos_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  function automatic int unsigned pos_max(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  function automatic int unsigned neg_max(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_negate_slice.sv
// serial_negate_slice
// One-bit slice of a serial two's-complement negation, LSB first.
// Bits up to and including the first 1 pass through unchanged; every later
// bit is inverted when sign is set.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : forget previously seen bits (start of a new word)
//   en           : a bit is being consumed this cycle
//   sign         : 1 = negate the stream
//   bit_in       : current input bit
//   bit_out      : current output bit (combinational)
module serial_negate_slice (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  input  logic sign,
  input  logic bit_in,
  output logic bit_out
);

  logic seen_one_q;
  logic seen_one_d;

  always_comb begin
    seen_one_d = seen_one_q;
    if (clear) begin
      seen_one_d = 1'b0;
    end else if (en) begin
      seen_one_d = seen_one_q | bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

  assign bit_out = (sign && seen_one_q) ? ~bit_in : bit_in;

endmodule

// File: rtl/sm_to_twos_serial.sv
// sm_to_twos_serial
// Converts a sign-magnitude entry into a WIDTH-bit two's-complement word,
// one bit per clock, LSB first. Out-of-range magnitudes are clamped before
// conversion and flagged on ovf; latency is the same either way.
//   clk, reset_n        : clock, synchronous active-low reset
//   in_valid / in_ready : input handshake (ready only while idle)
//   sign, mag           : sign (1 = negative) and unsigned magnitude
//   out_valid/out_ready : output handshake
//   dout, ovf           : result and saturation flag
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for a word, in_ready=1
// ST_CONVERT | shifting WIDTH bits through the negate slice
// ST_DONE    | result held on dout/ovf until out_ready
module sm_to_twos_serial
  import sm_to_twos_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAG_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [MAG_W-1:0] mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [MAG_W-1:0] POS_MAX_M = MAG_W'(pos_max(WIDTH));
  localparam logic [MAG_W-1:0] NEG_MAX_M = MAG_W'(neg_max(WIDTH));
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic             accept;
  logic             shift_en;
  logic             bit_out;

  serial_negate_slice u_negate (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .en      (shift_en),
    .sign    (sign_q),
    .bit_in  (work_q[0]),
    .bit_out (bit_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dout_d   = dout_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          sign_d  = sign;
          cnt_d   = CNT_LOAD;
          state_d = ST_CONVERT;
          // Clamp here so saturated values take the normal serial path.
          if (!sign && (mag > POS_MAX_M)) begin
            work_d = POS_MAX_M[WIDTH-1:0];
            ovf_d  = 1'b1;
          end else if (sign && (mag > NEG_MAX_M)) begin
            work_d = NEG_MAX_M[WIDTH-1:0];
            ovf_d  = 1'b1;
          end else begin
            work_d = mag[WIDTH-1:0];
            ovf_d  = 1'b0;
          end
        end
      end
      ST_CONVERT: begin
        shift_en = 1'b1;
        work_d   = work_q >> 1;
        // LSB-first stream enters at the MSB so bit 0 ends up at dout[0].
        dout_d   = {bit_out, dout_q[WIDTH-1:1]};
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dout_q  <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dout_q  <= dout_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule
